// File: rtl/ec_pkg.sv
// ---------------------------------------------------------------------------
// ec_pkg
// Shared definitions for the affine EC point sequencer:
//   - GF unit opcodes (add / sub / mult / div)
//   - operand file register indices
//   - microword layout {op, src_a, src_b, dst}
//   - microprogram base / last addresses for point add and point double
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package ec_pkg;

  typedef enum logic [1:0] {
    GF_ADD = 2'd0,
    GF_SUB = 2'd1,
    GF_MUL = 2'd2,
    GF_DIV = 2'd3   // in_0 * in_1^-1
  } gf_op_e;

  // Operand file map
  localparam logic [2:0] R_X1 = 3'd0;
  localparam logic [2:0] R_Y1 = 3'd1;
  localparam logic [2:0] R_X2 = 3'd2;
  localparam logic [2:0] R_Y2 = 3'd3;
  localparam logic [2:0] R_A  = 3'd4;
  localparam logic [2:0] R_T0 = 3'd5;
  localparam logic [2:0] R_T1 = 3'd6;
  localparam logic [2:0] R_T2 = 3'd7;

  typedef struct packed {
    gf_op_e     op;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dst;
  } uword_t;

  // Microprogram layout: ADD occupies 0..8, DBL occupies 9..20
  localparam logic [4:0] ADD_BASE = 5'd0;
  localparam logic [4:0] ADD_LAST = 5'd8;
  localparam logic [4:0] DBL_BASE = 5'd9;
  localparam logic [4:0] DBL_LAST = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic uword_t mk_uw(input gf_op_e op, input logic [2:0] a,
                                   input logic [2:0] b, input logic [2:0] d);
    uword_t w;
    w.op    = op;
    w.src_a = a;
    w.src_b = b;
    w.dst   = d;
    return w;
  endfunction

endpackage

// File: rtl/ec_ucode_rom.sv
// ---------------------------------------------------------------------------
// ec_ucode_rom
// Combinational microcode ROM holding the affine point-add and point-double
// programs. Each word is dst = src_a op src_b.
// Ports:
//   pc_i     in  5   microprogram counter
//   uword_o  out     microword at pc_i (unused addresses read as all-zero)
// ---------------------------------------------------------------------------
module ec_ucode_rom
  import ec_pkg::*;
(
  input  logic [4:0] pc_i,
  output uword_t     uword_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives uword_o; without it
    // an incomplete case would infer a latch.
    uword_o = '0;
    case (pc_i)
      // Point add: lambda = (y2-y1)/(x2-x1)
      5'd0:  uword_o = mk_uw(GF_SUB, R_Y2, R_Y1, R_T0);
      5'd1:  uword_o = mk_uw(GF_SUB, R_X2, R_X1, R_T1);
      5'd2:  uword_o = mk_uw(GF_DIV, R_T0, R_T1, R_T0);
      5'd3:  uword_o = mk_uw(GF_MUL, R_T0, R_T0, R_T1);
      5'd4:  uword_o = mk_uw(GF_SUB, R_T1, R_X1, R_T1);
      5'd5:  uword_o = mk_uw(GF_SUB, R_T1, R_X2, R_T1);
      5'd6:  uword_o = mk_uw(GF_SUB, R_X1, R_T1, R_T2);
      5'd7:  uword_o = mk_uw(GF_MUL, R_T0, R_T2, R_T2);
      5'd8:  uword_o = mk_uw(GF_SUB, R_T2, R_Y1, R_T2);
      // Point double: lambda = (3*x1^2 + a)/(2*y1)
      5'd9:  uword_o = mk_uw(GF_MUL, R_X1, R_X1, R_T0);
      5'd10: uword_o = mk_uw(GF_ADD, R_T0, R_T0, R_T1);
      5'd11: uword_o = mk_uw(GF_ADD, R_T1, R_T0, R_T0);
      5'd12: uword_o = mk_uw(GF_ADD, R_T0, R_A,  R_T0);
      5'd13: uword_o = mk_uw(GF_ADD, R_Y1, R_Y1, R_T1);
      5'd14: uword_o = mk_uw(GF_DIV, R_T0, R_T1, R_T0);
      5'd15: uword_o = mk_uw(GF_MUL, R_T0, R_T0, R_T1);
      5'd16: uword_o = mk_uw(GF_SUB, R_T1, R_X1, R_T1);
      5'd17: uword_o = mk_uw(GF_SUB, R_T1, R_X1, R_T1);
      5'd18: uword_o = mk_uw(GF_SUB, R_X1, R_T1, R_T2);
      5'd19: uword_o = mk_uw(GF_MUL, R_T0, R_T2, R_T2);
      5'd20: uword_o = mk_uw(GF_SUB, R_T2, R_Y1, R_T2);
      default: uword_o = '0;
    endcase
  end

endmodule

// File: rtl/ec_point_seq.sv
// ---------------------------------------------------------------------------
// ec_point_seq
// Affine elliptic-curve point sequencer over GF(p): P3 = P1+P2 or 2*P1 on
// y^2 = x^3 + a*x + b. Steps a fixed microprogram through an 8-entry operand
// file and drives an external GF arithmetic unit; no local arithmetic beyond
// equality compares.
// Ports:
//   i_clk, i_rst                 clock, async active-low reset
//   start, op_dbl                request pulse (IDLE only), 1 = double
//   x1, y1, x2, y2, curve_a      operands, already reduced mod p
//   x3, y3                       result, held until next start
//   done, busy, inf, err         completion pulse, activity, infinity, timeout
//   gf_in_0, gf_in_1, gf_op      GF operands / opcode (0 add 1 sub 2 mul 3 div)
//   gf_start                     one-cycle request strobe per microstep
//   gf_result                    GF result (add/sub same cycle)
//   gf_done_mult, gf_done_div    mult / div completion pulses
// ---------------------------------------------------------------------------
module ec_point_seq
  import ec_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            op_dbl,
  input  logic [SIZE-1:0] x1,
  input  logic [SIZE-1:0] y1,
  input  logic [SIZE-1:0] x2,
  input  logic [SIZE-1:0] y2,
  input  logic [SIZE-1:0] curve_a,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] y3,
  output logic            done,
  output logic            busy,
  output logic            inf,
  output logic            err,
  output logic [SIZE-1:0] gf_in_0,
  output logic [SIZE-1:0] gf_in_1,
  output logic [1:0]      gf_op,
  output logic            gf_start,
  input  logic [SIZE-1:0] gf_result,
  input  logic            gf_done_mult,
  input  logic            gf_done_div
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [4:0]      pc_q;
  logic [4:0]      last_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [SIZE-1:0] rf_q [8];
  logic [SIZE-1:0] x3_q, y3_q;
  logic            done_q, busy_q, inf_q, err_q;
  uword_t          uw;

  ec_ucode_rom u_rom (
    .pc_i    (pc_q),
    .uword_o (uw)
  );

  // Special-case decode, evaluated on the raw inputs while in LOAD.
  logic x_eq, y_eq, y1_zero, use_dbl, to_inf;
  always_comb begin
    x_eq    = (x1 == x2);
    y_eq    = (y1 == y2);
    y1_zero = (y1 == '0);
    // P1 == P2 under add is a doubling; doubling a point with y == 0 is O.
    use_dbl = op_dbl || (x_eq && y_eq);
    to_inf  = (!op_dbl && x_eq && !y_eq) || (use_dbl && y1_zero);
  end

  // Completion of the long operation currently parked in WAIT.
  logic long_done;
  always_comb begin
    long_done = (uw.op == GF_MUL) ? gf_done_mult :
                (uw.op == GF_DIV) ? gf_done_div  : 1'b0;
  end

  // GF request interface: decoded from the registered pc and operand file, so
  // it stays stable for the whole WAIT and reads as zero outside ISSUE/WAIT.
  always_comb begin
    gf_in_0  = '0;
    gf_in_1  = '0;
    gf_op    = 2'd0;
    gf_start = 1'b0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      gf_in_0  = rf_q[uw.src_a];
      gf_in_1  = rf_q[uw.src_b];
      gf_op    = uw.op;
      gf_start = (state_q == S_ISSUE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      last_q     <= '0;
      wait_cnt_q <= '0;
      // NOTE: the operand file is small and must read as zero after reset,
      // so it is reset like any other register rather than left as RAM.
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      x3_q       <= '0;
      y3_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      inf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block override the defaults below within the same cycle.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          // busy_q is still high in the done cycle, which blocks re-acceptance.
          if (start && !busy_q) begin
            busy_q  <= 1'b1;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          rf_q[R_X1] <= x1;
          rf_q[R_Y1] <= y1;
          rf_q[R_X2] <= x2;
          rf_q[R_Y2] <= y2;
          rf_q[R_A]  <= curve_a;
          rf_q[R_T0] <= '0;
          rf_q[R_T1] <= '0;
          rf_q[R_T2] <= '0;
          if (to_inf) begin
            inf_q   <= 1'b1;
            x3_q    <= '0;
            y3_q    <= '0;
            state_q <= S_DONE;
          end else begin
            pc_q    <= use_dbl ? DBL_BASE : ADD_BASE;
            last_q  <= use_dbl ? DBL_LAST : ADD_LAST;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wait_cnt_q <= '0;
          if (uw.op == GF_MUL || uw.op == GF_DIV) begin
            state_q <= S_WAIT;
          end else begin
            rf_q[uw.dst] <= gf_result;
            if (pc_q == last_q) state_q <= S_DONE;
            else                pc_q    <= pc_q + 5'd1;
          end
        end

        S_WAIT: begin
          if (long_done) begin
            rf_q[uw.dst] <= gf_result;
            if (pc_q == last_q) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_q + 5'd1;
              state_q <= S_ISSUE;
            end
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end

        S_DONE: begin
          if (!inf_q && !err_q) begin
            x3_q <= rf_q[R_T1];
            y3_q <= rf_q[R_T2];
          end
          done_q  <= 1'b1;
          pc_q    <= '0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x3   = x3_q;
  assign y3   = y3_q;
  assign done = done_q;
  assign busy = busy_q;
  assign inf  = inf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ec_point_seq.sv
// ---------------------------------------------------------------------------
// tb_ec_point_seq
// Curve y^2 = x^3 + 2x + 3 over GF(97). A behavioural GF unit with random
// mult/div latency serves the main instance; a second instance with
// TIMEOUT=16 never sees a mult/div completion. Expected results are pushed to
// per-instance queues and popped by monitors whenever done is observed.
// ---------------------------------------------------------------------------
module tb_ec_point_seq;
  import ec_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] x3;
    logic [W-1:0] y3;
    logic         inf;
    logic         err;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  exp_t to_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main instance
  logic         start, op_dbl;
  logic [W-1:0] x1, y1, x2, y2, curve_a;
  logic [W-1:0] x3, y3, gf_in_0, gf_in_1, gf_result;
  logic         done, busy, inf, err, gf_start, gf_done_mult, gf_done_div;
  logic [1:0]   gf_op;

  ec_point_seq #(.SIZE(W), .TIMEOUT(1023)) dut (
    .i_clk(clk), .i_rst(rst_n), .start(start), .op_dbl(op_dbl),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .curve_a(curve_a),
    .x3(x3), .y3(y3), .done(done), .busy(busy), .inf(inf), .err(err),
    .gf_in_0(gf_in_0), .gf_in_1(gf_in_1), .gf_op(gf_op), .gf_start(gf_start),
    .gf_result(gf_result), .gf_done_mult(gf_done_mult), .gf_done_div(gf_done_div)
  );

  // Timeout instance: GF unit never completes
  logic         t_start;
  logic [W-1:0] t_x3, t_y3, t_gf_in_0, t_gf_in_1;
  logic         t_done, t_busy, t_inf, t_err, t_gf_start;
  logic [1:0]   t_gf_op;

  ec_point_seq #(.SIZE(W), .TIMEOUT(16)) dut_to (
    .i_clk(clk), .i_rst(rst_n), .start(t_start), .op_dbl(1'b1),
    .x1(32'd3), .y1(32'd6), .x2(32'd0), .y2(32'd0), .curve_a(32'd2),
    .x3(t_x3), .y3(t_y3), .done(t_done), .busy(t_busy), .inf(t_inf), .err(t_err),
    .gf_in_0(t_gf_in_0), .gf_in_1(t_gf_in_1), .gf_op(t_gf_op), .gf_start(t_gf_start),
    .gf_result(32'd0), .gf_done_mult(1'b0), .gf_done_div(1'b0)
  );

  // ---------------- GF(97) behavioural unit ----------------
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a + b) % 32'd97;
  endfunction
  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a + 32'd97 - b) % 32'd97;
  endfunction
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a * b) % 32'd97;
  endfunction
  function automatic logic [W-1:0] finv(input logic [W-1:0] b);
    for (int i = 1; i < 97; i++)
      if ((b * 32'(i)) % 32'd97 == 32'd1) return 32'(i);
    return 32'd0;
  endfunction

  logic         pend;
  logic [1:0]   pend_op;
  int           lat;
  logic [W-1:0] long_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; pend_op <= 2'd0; lat <= 0; long_res <= '0;
      gf_done_mult <= 1'b0; gf_done_div <= 1'b0;
    end else begin
      gf_done_mult <= 1'b0;
      gf_done_div  <= 1'b0;
      if (pend) begin
        if (lat == 0) begin
          pend <= 1'b0;
          if (pend_op == 2'd2) gf_done_mult <= 1'b1;
          else                 gf_done_div  <= 1'b1;
        end else begin
          lat <= lat - 1;
        end
      end
      if (gf_start && gf_op[1]) begin
        pend     <= 1'b1;
        pend_op  <= gf_op;
        lat      <= int'($urandom_range(3, 38));
        long_res <= (gf_op == 2'd2) ? fmul(gf_in_0, gf_in_1)
                                    : fmul(gf_in_0, finv(gf_in_1));
      end
    end
  end

  assign gf_result = gf_op[1] ? long_res :
                     (gf_op == 2'd0) ? fadd(gf_in_0, gf_in_1) : fsub(gf_in_0, gf_in_1);

  // ---------------- event counters ----------------
  int gs_cnt = 0, t_gs_cnt = 0, done_cnt = 0, t_done_cnt = 0;
  always @(posedge clk) begin
    if (gf_start)   gs_cnt   <= gs_cnt + 1;
    if (t_gf_start) t_gs_cnt <= t_gs_cnt + 1;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt <= done_cnt + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x3", x3, e.x3);
        check("y3", y3, e.y3);
        check("inf", {31'd0, inf}, {31'd0, e.inf});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && t_done) begin
      t_done_cnt <= t_done_cnt + 1;
      if (to_q.size() == 0) begin
        check("to_unexpected_done", {31'd0, t_done}, 32'd0);
      end else begin
        exp_t e;
        e = to_q.pop_front();
        check("to_x3", t_x3, e.x3);
        check("to_y3", t_y3, e.y3);
        check("to_inf", {31'd0, t_inf}, {31'd0, e.inf});
        check("to_err", {31'd0, t_err}, {31'd0, e.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input string name, input logic dbl,
                        input logic [W-1:0] ax1, input logic [W-1:0] ay1,
                        input logic [W-1:0] ax2, input logic [W-1:0] ay2,
                        input logic [W-1:0] ex3, input logic [W-1:0] ey3,
                        input logic einf, input int steps, input int exp_lat);
    exp_t e;
    int   n, gs0, dc0;
    e.x3 = ex3; e.y3 = ey3; e.inf = einf; e.err = 1'b0;
    exp_q.push_back(e);
    op_dbl = dbl; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; curve_a = 32'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gs0 = gs_cnt;
    dc0 = done_cnt;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    if (exp_lat >= 0) check({name, "_latency"}, n, exp_lat);
    @(negedge clk);
    check({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_gf_starts"}, gs_cnt - gs0, steps);
    check({name, "_done_count"}, done_cnt - dc0, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, gs0, dc0;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; op_dbl = 1'b0; t_start = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; curve_a = '0;
    repeat (3) @(negedge clk);
    check("rst_x3", x3, 32'd0);
    check("rst_y3", y3, 32'd0);
    check("rst_flags", {28'd0, done, busy, inf, err}, 32'd0);
    check("rst_gf", {29'd0, gf_start, gf_op} | gf_in_0 | gf_in_1, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("dbl_3_6",     1'b1, 32'd3, 32'd6, 32'd0,  32'd0,  32'd80, 32'd10, 1'b0, 12, -1);
    run_op("add_3_6_80",  1'b0, 32'd3, 32'd6, 32'd80, 32'd10, 32'd80, 32'd87, 1'b0,  9, -1);
    run_op("add_same",    1'b0, 32'd3, 32'd6, 32'd3,  32'd6,  32'd80, 32'd10, 1'b0, 12, -1);
    run_op("add_inverse", 1'b0, 32'd3, 32'd6, 32'd3,  32'd91, 32'd0,  32'd0,  1'b1,  0,  2);
    run_op("dbl_y0",      1'b1, 32'd3, 32'd0, 32'd0,  32'd0,  32'd0,  32'd0,  1'b1,  0,  2);

    // Timeout on the TIMEOUT=16 instance, with a start pulse while busy.
    e.x3 = 32'd0; e.y3 = 32'd0; e.inf = 1'b0; e.err = 1'b1;
    to_q.push_back(e);
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    gs0 = t_gs_cnt;
    dc0 = t_done_cnt;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      t_start = (n == 5);
      if (t_done) break;
    end
    t_start = 1'b0;
    check("to_done_seen", {31'd0, t_done}, 32'd1);
    check("to_latency", n, 32'd19);
    check("to_busy_at_done", {31'd0, t_busy}, 32'd1);
    repeat (40) @(negedge clk);
    check("to_busy_idle", {31'd0, t_busy}, 32'd0);
    check("to_done_count", t_done_cnt - dc0, 32'd1);
    check("to_gf_starts", t_gs_cnt - gs0, 32'd1);

    // Reset in the middle of WAIT: no done, all outputs cleared.
    op_dbl = 1'b1; x1 = 32'd3; y1 = 32'd6; x2 = '0; y2 = '0; curve_a = 32'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gf_start) break;
      @(negedge clk);
    end
    check("abort_saw_gf_start", {31'd0, gf_start}, 32'd1);
    check("abort_first_op_mult", {30'd0, gf_op}, 32'd2);
    repeat (2) @(negedge clk);
    check("abort_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_x3", x3, 32'd0);
    check("abort_y3", y3, 32'd0);
    check("abort_flags", {28'd0, done, busy, inf, err}, 32'd0);
    check("abort_gf", {29'd0, gf_start, gf_op} | gf_in_0 | gf_in_1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);

    run_op("dbl_after_rst", 1'b1, 32'd3, 32'd6, 32'd0, 32'd0, 32'd80, 32'd10, 1'b0, 12, -1);

    check("sb_empty", exp_q.size(), 32'd0);
    check("to_sb_empty", to_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
